// File: rtl/obi_monitor_pkg.sv
// Shared types and constants for the OBI data-interface monitor.
// Latency: none (package only).
// Backpressure: none (package only).
package obi_monitor_pkg;

    // Stability checker states: IDLE = no request pending, WAIT = req held without gnt.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } obi_state_e;

    // Width of one tracker entry {we, be, addr}.
    function automatic int unsigned obi_entry_width(input int unsigned addr_w,
                                                    input int unsigned data_w);
        return 1 + data_w / 8 + addr_w;
    endfunction

    // Bit positions of the sticky error flags in the packed error vector.
    localparam int unsigned ERR_GNT_NO_REQ     = 0;
    localparam int unsigned ERR_RVALID_NO_PEND = 1;
    localparam int unsigned ERR_REQ_DROP       = 2;
    localparam int unsigned ERR_UNSTABLE       = 3;
    localparam int unsigned ERR_OVERFLOW       = 4;
    localparam int unsigned ERR_NUM            = 5;

endpackage

// File: rtl/obi_monitor_fifo.sv
// In-order circular FIFO with modulo-DEPTH pointers (non-power-of-two depths allowed).
// Latency: head entry visible the cycle after push; pop takes effect at the clock edge.
// Backpressure: push into a full FIFO is dropped unless a pop happens in the same cycle.
module obi_monitor_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int unsigned      PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full_o     = (count_q == DEPTH_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign do_pop     = pop_i && !empty_o;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign do_push    = push_i && (!full_o || do_pop);

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/obi_data_monitor.sv
// OBI data-interface monitor: in-order transaction tracker, stability checker, sticky error flags.
// Latency: rsp_* one cycle after a legal rvalid; error flags one cycle after the offending cycle.
// Backpressure: none, passive observer; optional OBI_DATA_MONITOR_ASSUME_EN adds formal properties.
module obi_data_monitor
    import obi_monitor_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    data_req_i,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    input  logic [DATA_WIDTH-1:0]   data_rdata_i,
    output logic [CNT_WIDTH-1:0]    outstanding_o,
    output logic                    rsp_valid_o,
    output logic                    rsp_we_o,
    output logic [DATA_WIDTH/8-1:0] rsp_be_o,
    output logic [ADDR_WIDTH-1:0]   rsp_addr_o,
    output logic                    err_gnt_no_req_o,
    output logic                    err_rvalid_no_pend_o,
    output logic                    err_req_drop_o,
    output logic                    err_unstable_o,
    output logic                    err_overflow_o,
    output logic                    err_any_o
);
    localparam int unsigned BE_W    = DATA_WIDTH / 8;
    localparam int unsigned ENTRY_W = obi_entry_width(ADDR_WIDTH, DATA_WIDTH);

    typedef struct packed {
        logic                  we;
        logic [BE_W-1:0]       be;
        logic [ADDR_WIDTH-1:0] addr;
    } entry_t;

    typedef struct packed {
        entry_t                meta;
        logic [DATA_WIDTH-1:0] wdata;
    } cap_t;

    entry_t             cur_entry;
    cap_t               cur_cap;
    entry_t             head_entry;
    logic [ENTRY_W-1:0] head_dat;
    logic               accept;
    logic               retire;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fields_differ;
    logic               drop_set;
    logic               unstable_set;
    logic [ERR_NUM-1:0] err_set;
    logic [ERR_NUM-1:0] err_q;
    obi_state_e         state_q, state_d;
    cap_t               cap_q, cap_d;
    logic               rsp_valid_q;
    entry_t             rsp_q;
    logic               unused_rdata;

    // Read data is carried on the interface but never inspected.
    assign unused_rdata = ^data_rdata_i;

    assign cur_entry  = '{we: data_we_i, be: data_be_i, addr: data_addr_i};
    assign cur_cap    = '{meta: cur_entry, wdata: data_wdata_i};
    assign head_entry = entry_t'(head_dat);

    assign accept = data_req_i && data_gnt_i;
    // An rvalid with nothing outstanding is an error, not a retire.
    assign retire = data_rvalid_i && !fifo_empty;

    obi_monitor_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_WIDTH)
    ) u_tracker (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (accept),
        .push_dat_i (cur_entry),
        .pop_i      (retire),
        .head_dat_o (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (outstanding_o)
    );

    // wdata only has to be stable for writes.
    assign fields_differ = (data_we_i   != cap_q.meta.we)   ||
                           (data_be_i   != cap_q.meta.be)   ||
                           (data_addr_i != cap_q.meta.addr) ||
                           (cap_q.meta.we && (data_wdata_i != cap_q.wdata));

    // Stability FSM: capture on an ungranted request, then watch it until grant or drop.
    always_comb begin
        state_d      = state_q;
        cap_d        = cap_q;
        drop_set     = 1'b0;
        unstable_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_req_i && !data_gnt_i) begin
                    state_d = WAIT;
                    cap_d   = cur_cap;
                end
            end
            WAIT: begin
                if (!data_req_i) begin
                    drop_set = 1'b1;
                    state_d  = IDLE;
                end else begin
                    // Original capture is kept so later changes are judged against it.
                    unstable_set = fields_differ;
                    if (data_gnt_i) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stability FSM state and capture registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
        end
    end

    // Per-cycle violation detection, packed by error index.
    always_comb begin
        err_set                     = '0;
        err_set[ERR_GNT_NO_REQ]     = data_gnt_i && !data_req_i;
        err_set[ERR_RVALID_NO_PEND] = data_rvalid_i && fifo_empty;
        err_set[ERR_REQ_DROP]       = drop_set;
        err_set[ERR_UNSTABLE]       = unstable_set;
        err_set[ERR_OVERFLOW]       = accept && fifo_full && !data_rvalid_i;
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= '0;
        end else begin
            err_q <= err_q | err_set;
        end
    end

    // Response register: pulse valid on retire, hold metadata otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            rsp_valid_q <= retire;
            if (retire) begin
                rsp_q <= head_entry;
            end
        end
    end

    assign rsp_valid_o          = rsp_valid_q;
    assign rsp_we_o             = rsp_q.we;
    assign rsp_be_o             = rsp_q.be;
    assign rsp_addr_o           = rsp_q.addr;
    assign err_gnt_no_req_o     = err_q[ERR_GNT_NO_REQ];
    assign err_rvalid_no_pend_o = err_q[ERR_RVALID_NO_PEND];
    assign err_req_drop_o       = err_q[ERR_REQ_DROP];
    assign err_unstable_o       = err_q[ERR_UNSTABLE];
    assign err_overflow_o       = err_q[ERR_OVERFLOW];
    assign err_any_o            = |err_q;

`ifdef OBI_DATA_MONITOR_ASSUME_EN
    // Memory side is constrained; the core side is proven.
    asm_gnt_needs_req: assume property (@(posedge clk_i) disable iff (!rst_ni)
        !data_req_i |-> !data_gnt_i);
    asm_rvalid_needs_pend: assume property (@(posedge clk_i) disable iff (!rst_ni)
        (outstanding_o == '0) |-> !data_rvalid_i);
    asm_no_gnt_when_full: assume property (@(posedge clk_i) disable iff (!rst_ni)
        ((outstanding_o == CNT_WIDTH'(MAX_OUTSTANDING)) && !data_rvalid_i) |-> !data_gnt_i);
    ast_core_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !err_req_drop_o && !err_unstable_o);
`else
    // Plain monitor build: flags only, no properties.
`endif

endmodule

// File: tb/tb_obi_data_monitor.sv
// Self-checking bench for obi_data_monitor at depth 2 and depth 3.
// Latency: expected responses queued at stimulus, popped when rsp_valid_o is seen.
// Backpressure: none; inputs are driven directly each cycle.
module tb_obi_data_monitor;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, gnt = 1'b0, rvalid = 1'b0, we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = '0, wdata = '0, rdata = '0;

    logic [1:0]  outst2, outst3;
    logic        rspv2, rspwe2, rspv3, rspwe3;
    logic [3:0]  rspbe2, rspbe3;
    logic [31:0] rspaddr2, rspaddr3;
    logic        gnr2, rnp2, drop2, unst2, ovf2, any2;
    logic        gnr3, rnp3, drop3, unst3, ovf3, any3;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   rsp3_cnt = 0;
    bit   mon2_en = 1'b0;
    bit   mon3_en = 1'b0;
    ent_t q2[$];
    ent_t q3[$];
    ent_t e2, e3, ne;
    int   issued, cnt3;

    always #5 clk = ~clk;

    obi_data_monitor #(.MAX_OUTSTANDING(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_gnt_i(gnt),
        .data_rvalid_i(rvalid), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
        .data_wdata_i(wdata), .data_rdata_i(rdata), .outstanding_o(outst2),
        .rsp_valid_o(rspv2), .rsp_we_o(rspwe2), .rsp_be_o(rspbe2), .rsp_addr_o(rspaddr2),
        .err_gnt_no_req_o(gnr2), .err_rvalid_no_pend_o(rnp2), .err_req_drop_o(drop2),
        .err_unstable_o(unst2), .err_overflow_o(ovf2), .err_any_o(any2)
    );

    obi_data_monitor #(.MAX_OUTSTANDING(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_gnt_i(gnt),
        .data_rvalid_i(rvalid), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
        .data_wdata_i(wdata), .data_rdata_i(rdata), .outstanding_o(outst3),
        .rsp_valid_o(rspv3), .rsp_we_o(rspwe3), .rsp_be_o(rspbe3), .rsp_addr_o(rspaddr3),
        .err_gnt_no_req_o(gnr3), .err_rvalid_no_pend_o(rnp3), .err_req_drop_o(drop3),
        .err_unstable_o(unst3), .err_overflow_o(ovf3), .err_any_o(any3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic g, input logic v, input logic w,
                         input logic [3:0] b, input logic [31:0] a, input logic [31:0] wd);
        req = r; gnt = g; rvalid = v; we = w; be = b; addr = a; wdata = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Scoreboard monitor for the depth-2 instance.
    always @(negedge clk) begin
        if (rst_n && mon2_en && rspv2) begin
            if (q2.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp2_unexpected: got addr %0h, expected no response", rspaddr2);
            end else begin
                e2 = q2.pop_front();
                check("rsp2_meta", {27'h0, rspwe2, rspbe2, rspaddr2}, {27'h0, e2});
            end
        end
    end

    // Scoreboard monitor for the depth-3 instance.
    always @(negedge clk) begin
        if (rst_n && mon3_en && rspv3) begin
            rsp3_cnt++;
            if (q3.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp3_unexpected: got addr %0h, expected no response", rspaddr3);
            end else begin
                e3 = q3.pop_front();
                check("rsp3_meta", {27'h0, rspwe3, rspbe3, rspaddr3}, {27'h0, e3});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        do_reset();
        mon2_en = 1'b1;

        // Reset state.
        check("rst_outst", outst2, 0);
        check("rst_rspv", rspv2, 0);
        check("rst_rspaddr", rspaddr2, 0);
        check("rst_err_any", any2, 0);

        // Single read at 0x100.
        drive(1, 1, 0, 0, 4'hF, 32'h100, 32'h0);
        q2.push_back('{we: 1'b0, be: 4'hF, addr: 32'h100});
        step();
        check("rd_outst_after_gnt", outst2, 1);
        idle();
        step();
        check("rd_outst_wait", outst2, 1);
        check("rd_rspv_wait", rspv2, 0);
        drive(0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
        step();
        check("rd_outst_after_rvalid", outst2, 0);
        check("rd_rspv", rspv2, 1);
        check("rd_err_any", any2, 0);
        idle();
        step();
        check("rd_rspv_pulse", rspv2, 0);

        // Overflow: three grants into a depth-2 tracker.
        drive(1, 1, 0, 0, 4'hF, 32'h10, 32'h0);
        q2.push_back('{we: 1'b0, be: 4'hF, addr: 32'h10});
        step();
        drive(1, 1, 0, 1, 4'h3, 32'h14, 32'hAA);
        q2.push_back('{we: 1'b1, be: 4'h3, addr: 32'h14});
        step();
        check("ovf_outst_2", outst2, 2);
        check("ovf_not_yet", ovf2, 0);
        drive(1, 1, 0, 0, 4'hF, 32'h18, 32'h0);
        step();
        check("ovf_outst_sat", outst2, 2);
        check("ovf_flag", ovf2, 1);

        // Full tracker, grant and rvalid together: slot freed, order kept.
        drive(1, 1, 1, 0, 4'hC, 32'h1C, 32'h0);
        q2.push_back('{we: 1'b0, be: 4'hC, addr: 32'h1C});
        step();
        check("full_swap_outst", outst2, 2);
        check("full_swap_rspaddr", rspaddr2, 32'h10);
        drive(1, 1, 1, 1, 4'h1, 32'h20, 32'h55);
        q2.push_back('{we: 1'b1, be: 4'h1, addr: 32'h20});
        step();
        check("full_swap2_outst", outst2, 2);
        drive(0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
        step();
        check("drain_outst_1", outst2, 1);
        step();
        check("drain_outst_0", outst2, 0);
        idle();
        step();
        check("ovf_sticky", ovf2, 1);
        check("ovf_q_empty", q2.size(), 0);
        do_reset();
        check("ovf_cleared", any2, 0);

        // Address change while waiting for grant.
        drive(1, 0, 0, 0, 4'hF, 32'h200, 32'h0);
        step();
        drive(1, 0, 0, 0, 4'hF, 32'h204, 32'h0);
        step();
        check("unstable_flag", unst2, 1);
        check("unstable_no_drop", drop2, 0);
        drive(1, 1, 0, 0, 4'hF, 32'h204, 32'h0);
        q2.push_back('{we: 1'b0, be: 4'hF, addr: 32'h204});
        step();
        drive(0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
        step();
        idle();
        step();
        check("unstable_q_empty", q2.size(), 0);
        do_reset();

        // wdata changes on a read are ignored; then a dropped request.
        drive(1, 0, 0, 0, 4'hF, 32'h400, 32'h1111);
        step();
        drive(1, 0, 0, 0, 4'hF, 32'h400, 32'h2222);
        step();
        check("rd_wdata_ignored", unst2, 0);
        drive(1, 1, 0, 0, 4'hF, 32'h400, 32'h3333);
        q2.push_back('{we: 1'b0, be: 4'hF, addr: 32'h400});
        step();
        drive(0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
        step();
        drive(1, 0, 0, 0, 4'hF, 32'h300, 32'h0);
        step();
        idle();
        step();
        check("drop_flag", drop2, 1);
        check("drop_no_unstable", unst2, 0);
        do_reset();

        // wdata change on a write is a violation.
        drive(1, 0, 0, 1, 4'hF, 32'h500, 32'hA5A5);
        step();
        drive(1, 0, 0, 1, 4'hF, 32'h500, 32'h5A5A);
        step();
        check("wr_wdata_unstable", unst2, 1);
        drive(1, 1, 0, 1, 4'hF, 32'h500, 32'h5A5A);
        q2.push_back('{we: 1'b1, be: 4'hF, addr: 32'h500});
        step();
        drive(0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
        step();
        idle();
        step();
        check("wr_q_empty", q2.size(), 0);
        do_reset();

        // Spurious rvalid and grant without request; sticky until reset.
        drive(0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
        step();
        check("rnp_flag", rnp2, 1);
        check("rnp_rspv", rspv2, 0);
        check("rnp_outst", outst2, 0);
        drive(0, 1, 0, 0, 4'h0, 32'h0, 32'h0);
        step();
        check("gnr_flag", gnr2, 1);
        check("gnr_outst", outst2, 0);
        check("rnp_sticky", rnp2, 1);
        check("err_any_set", any2, 1);
        drive(1, 1, 0, 0, 4'hF, 32'h600, 32'h0);
        step();
        idle();
        step();
        check("pre_rst_outst", outst2, 1);
        check("gnr_still_sticky", gnr2, 1);
        rst_n = 1'b0;
        #2;
        check("async_rst_outst", outst2, 0);
        check("async_rst_err_any", any2, 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_gnr", gnr2, 0);
        check("post_rst_rnp", rnp2, 0);
        drive(0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
        step();
        check("dropped_entry_gone", rnp2, 1);
        check("dropped_entry_rspv", rspv2, 0);
        idle();
        step();
        mon2_en = 1'b0;
        do_reset();

        // Depth 3: in-order traffic with pointer wrap.
        mon3_en = 1'b1;
        issued = 0;
        cnt3 = 0;
        for (int cyc = 0; cyc < 300 && !(issued == 10 && cnt3 == 0); cyc++) begin
            logic iss;
            logic rv;
            iss = (issued < 10) && ($urandom_range(0, 2) != 0);
            rv  = (cnt3 > 0) && ($urandom_range(0, 1) == 1);
            if (iss && cnt3 == 3 && !rv) iss = 1'b0;
            if (iss) begin
                ne.we   = 1'($urandom_range(0, 1));
                ne.be   = 4'($urandom_range(1, 15));
                ne.addr = $urandom & 32'hFFFF_FFFC;
                q3.push_back(ne);
                drive(1, 1, rv, ne.we, ne.be, ne.addr, $urandom);
                issued++;
            end else begin
                drive(0, 0, rv, 0, 4'h0, 32'h0, 32'h0);
            end
            step();
            cnt3 = cnt3 + (iss ? 1 : 0) - (rv ? 1 : 0);
            check("d3_outst", outst3, cnt3);
        end
        idle();
        step();
        step();
        check("d3_all_issued", issued, 10);
        check("d3_drained", cnt3, 0);
        check("d3_rsp_count", rsp3_cnt, 10);
        check("d3_q_empty", q3.size(), 0);
        check("d3_err_any", any3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/obi_data_monitor.md
Name: obi_data_monitor

Overview:
- Parametrised, synthesizable monitor for the CV32E40P OBI data interface, used in formal and simulation benches.
- Replaces the single outstanding counter with a bounded in-order transaction tracker that checks the core side and the memory side of the handshake.
- Reports sticky violation flags, and returns the request metadata (address, we, be) of each response as it arrives.
- Sits beside the core in the formal top; every port is an input except the monitor outputs.

Parameters:
- ADDR_WIDTH, 32, width of data_addr_i
- DATA_WIDTH, 32, width of data_wdata_i and data_rdata_i; must be a multiple of 8
- MAX_OUTSTANDING, 2, tracker depth (maximum granted but unanswered transactions); must be >= 1
- CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), width of the outstanding count

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_req_i  in  1  core request
- data_gnt_i  in  1  memory grant
- data_rvalid_i  in  1  memory response valid
- data_we_i  in  1  write enable
- data_be_i  in  DATA_WIDTH/8  byte enables
- data_addr_i  in  ADDR_WIDTH  address
- data_wdata_i  in  DATA_WIDTH  write data
- data_rdata_i  in  DATA_WIDTH  read data (not checked; kept for the interface)
- outstanding_o  out  CNT_WIDTH  number of granted, unanswered transactions
- rsp_valid_o  out  1  registered copy of a legal data_rvalid_i
- rsp_we_o / rsp_be_o / rsp_addr_o  out  1 / DATA_WIDTH/8 / ADDR_WIDTH  metadata of the transaction just answered
- err_gnt_no_req_o  out  1  sticky: gnt seen without req
- err_rvalid_no_pend_o  out  1  sticky: rvalid seen with nothing outstanding
- err_req_drop_o  out  1  sticky: req deasserted before gnt
- err_unstable_o  out  1  sticky: addr/we/be/wdata changed while req && !gnt
- err_overflow_o  out  1  sticky: grant accepted with the tracker full and no rvalid in the same cycle
- err_any_o  out  1  OR of all err_* outputs (combinational)

Behaviour:
- Reset: every output is 0; tracker is empty; the pending-request capture is cleared.
- Accept = data_req_i && data_gnt_i. Retire = data_rvalid_i && (count > 0).
- Tracker: circular FIFO of {we, be, addr}, depth MAX_OUTSTANDING.
  - Pointers wrap modulo MAX_OUTSTANDING, so non-power-of-two depths are supported.
  - Accept pushes; retire pops the head in order.
- Count update: accept and retire together leave the count unchanged and do push+pop (with an empty tracker, this is a pure push); accept only adds 1; retire only subtracts 1.
- Full tracker, accept and rvalid in the same cycle: the pop frees the slot, so no overflow.
- Full tracker, accept without rvalid: set err_overflow_o; the push is dropped and the count saturates at MAX_OUTSTANDING.
- Response path, 1-cycle latency: on retire, the next cycle has rsp_valid_o = 1 and rsp_* = popped head entry.
  - Otherwise rsp_valid_o = 0 and rsp_* hold their last value.
- Empty tracker with rvalid: set err_rvalid_no_pend_o; no pop, count stays 0, rsp_valid_o stays 0.
- data_gnt_i && !data_req_i: set err_gnt_no_req_o; no push.
- Stability FSM, states IDLE and WAIT:
  - IDLE -> WAIT on req && !gnt; {we, be, addr, wdata} are captured.
  - In WAIT:
    - !req: set err_req_drop_o, go to IDLE.
    - req with any field differing from the capture: set err_unstable_o; stay in WAIT and keep the original capture.
    - req && gnt: go to IDLE.
  - Accept from IDLE completes in the same cycle; the FSM stays in IDLE.
  - wdata is compared only when the captured we = 1.
- Sticky flags clear only on reset. Asserting rst_ni mid-transaction drops all tracked entries.

Optional Feature:
- Macro OBI_DATA_MONITOR_ASSUME_EN.
- Defined: the block also emits concurrent properties on the memory side, each disabled iff !rst_ni:
  - assume !data_req_i |-> !data_gnt_i
  - assume outstanding_o == 0 |-> !data_rvalid_i
  - assume outstanding_o == MAX_OUTSTANDING && !data_rvalid_i |-> !data_gnt_i
  - assert err_req_drop_o == 0 and err_unstable_o == 0
  - This constrains the formal environment and proves the core side.
- Undefined: no properties are compiled; the block is a pure RTL monitor and the flags are identical.

Decomposition:
- Package obi_monitor_pkg:
  - typedef obi_state_e {IDLE, WAIT}
  - localparam-style function for the entry width (1 + DATA_WIDTH/8 + ADDR_WIDTH)
  - error-index constants used to pack err_* for bench reporting
- Sub-module obi_monitor_fifo:
  - generic depth/width in-order FIFO with push, pop, full, empty and count
  - instantiated once for the tracker

Test Plan:
- Read at 0x100 granted at cycle 2, rvalid at cycle 4 -> outstanding_o 1 in cycle 3, 0 in cycle 5; rsp_valid_o = 1 in cycle 5 with rsp_addr_o = 0x100, rsp_we_o = 0; all err_* = 0.
- MAX_OUTSTANDING = 2: three back-to-back grants with no rvalid -> outstanding_o saturates at 2; err_overflow_o = 1 from the cycle after the third grant.
- Full tracker, grant and rvalid in the same cycle -> count stays 2; no overflow; rsp_addr_o = oldest address; FIFO order preserved over 4 transactions.
- req high, gnt low, addr changes 0x200 -> 0x204 -> err_unstable_o = 1 next cycle; req dropped before gnt in another run -> err_req_drop_o = 1.
- rvalid with outstanding_o = 0, and gnt with req = 0 -> err_rvalid_no_pend_o and err_gnt_no_req_o set and sticky; err_any_o = 1; both clear only after rst_ni pulses low with 1 outstanding, leaving outstanding_o = 0.
- MAX_OUTSTANDING = 3 (non-power-of-two): 10 random in-order transactions -> pointer wrap correct; every rsp_* matches its request.
